// File: rtl/demux1_n_reg.sv
// Registered 1-to-N demultiplexer with valid/ready handshake and broadcast.
// Each output channel is a one-entry buffer that can drain and reload in the same cycle.
module demux1_n_reg #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_bcast,
    output logic               in_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic               sel_err
);
    // state | meaning
    // EMPTY | channel buffer holds no word, out_valid[k]=0
    // FULL  | channel buffer holds a word waiting for out_ready[k]
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_t;

    chan_state_t  state [N];
    logic [N-1:0] can_take;
    logic [N-1:0] sel_hit;
    logic [N-1:0] load;
    logic         sel_ok;
    logic         accept;

    always_comb begin
        can_take = '0;
        sel_hit  = '0;
        for (int k = 0; k < N; k++) begin
            can_take[k] = (state[k] == EMPTY) || out_ready[k];
            sel_hit[k]  = (in_sel == SEL_W'(k));
        end
    end

    // An out-of-range select matches no channel, so it is always accepted and dropped.
    assign sel_ok   = |sel_hit;
    assign in_ready = in_bcast ? (&can_take)
                               : (sel_ok ? (|(sel_hit & can_take)) : 1'b1);
    assign accept   = in_valid && in_ready;

    always_comb begin
        load = '0;
        if (accept) begin
            load = in_bcast ? {N{1'b1}} : sel_hit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                state[k] <= EMPTY;
            end
            out_data <= '0;
            sel_err  <= 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (load[k]) begin
                    state[k]                   <= FULL;
                    out_data[k*WIDTH +: WIDTH] <= in_data;
                end else if (out_ready[k]) begin
                    state[k] <= EMPTY;
                end
            end
            sel_err <= accept && !in_bcast && !sel_ok;
        end
    end

    always_comb begin
        out_valid = '0;
        for (int k = 0; k < N; k++) begin
            out_valid[k] = (state[k] == FULL);
        end
    end

endmodule

// File: tb/tb_demux1_n_reg.sv
// Bench for demux1_n_reg: four parameter sets, each with a per-channel queue scoreboard.
// The driver pushes expected words on accept; an independent monitor pops and compares.
module tb_demux1_n_reg;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    logic clk      = 1'b0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : h
        localparam int NN = (g == 0) ? 4 : (g == 1) ? 3 : (g == 2) ? 2 : 16;
        localparam int WW = (g == 2) ? 1 : (g == 3) ? 32 : 16;
        localparam int SS = (g == 2) ? 1 : (g == 3) ? 4 : 2;
        localparam logic [NN-1:0] ALL = '1;

        logic             rst;
        logic [WW-1:0]    in_data;
        logic             in_valid;
        logic [SS-1:0]    in_sel;
        logic             in_bcast;
        logic             in_ready;
        logic [NN*WW-1:0] out_data;
        logic [NN-1:0]    out_valid;
        logic [NN-1:0]    out_ready;
        logic             sel_err;

        logic [WW-1:0] exp_q [NN][$];
        logic          exp_sel_err = 1'b0;
        bit            pop_k [NN];

        demux1_n_reg #(.WIDTH(WW), .N(NN), .SEL_W(SS)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_data   (in_data),
            .in_valid  (in_valid),
            .in_sel    (in_sel),
            .in_bcast  (in_bcast),
            .in_ready  (in_ready),
            .out_data  (out_data),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .sel_err   (sel_err)
        );

        // A channel can take a word if its buffer is empty or it is being drained now.
        function automatic bit model_ready(input int sel, input bit bc);
            bit r;
            if (bc) begin
                r = 1'b1;
                for (int k = 0; k < NN; k++) begin
                    if (exp_q[k].size() != 0 && !out_ready[k]) r = 1'b0;
                end
            end else if (sel >= NN) begin
                r = 1'b1;
            end else begin
                r = (exp_q[sel].size() == 0) || out_ready[sel];
            end
            return r;
        endfunction

        task automatic cycle(input bit v, input int sel, input bit bc,
                             input logic [WW-1:0] d, input logic [NN-1:0] rdy);
            bit acc;
            bit er;
            in_valid  = v;
            in_sel    = SS'(sel);
            in_bcast  = bc;
            in_data   = d;
            out_ready = rdy;
            @(negedge clk);
            er  = model_ready(sel, bc);
            acc = v && er;
            check($sformatf("h%0d in_ready sel=%0d bc=%0d", g, sel, bc), 64'(in_ready), 64'(er));
            @(posedge clk);
            if (acc) begin
                for (int k = 0; k < NN; k++) begin
                    if (bc || sel == k) exp_q[k].push_back(d);
                end
            end
            exp_sel_err = acc && !bc && (sel >= NN);
            #1;
        endtask

        task automatic do_reset();
            #2 rst = 1'b1;
            #1;
            check($sformatf("h%0d async rst out_valid", g), 64'(out_valid), 64'(0));
            check($sformatf("h%0d async rst out_data", g), 64'(|out_data), 64'(0));
            check($sformatf("h%0d async rst sel_err", g), 64'(sel_err), 64'(0));
            for (int k = 0; k < NN; k++) exp_q[k].delete();
            exp_sel_err = 1'b0;
            in_valid  = 1'b1;
            in_bcast  = 1'b1;
            in_data   = '1;
            out_ready = '0;
            @(negedge clk);
            check($sformatf("h%0d in_ready in rst", g), 64'(in_ready), 64'(1));
            @(posedge clk);
            #1;
            check($sformatf("h%0d no accept in rst", g), 64'(out_valid), 64'(0));
            in_valid = 1'b0;
            rst      = 1'b0;
            #1;
            check($sformatf("h%0d in_ready after rst", g), 64'(in_ready), 64'(1));
        endtask

        initial begin : monitor
            forever begin
                @(negedge clk);
                for (int k = 0; k < NN; k++) pop_k[k] = 1'b0;
                if (!rst) begin
                    for (int k = 0; k < NN; k++) begin
                        check($sformatf("h%0d out_valid ch%0d", g, k),
                              64'(out_valid[k]), 64'(exp_q[k].size() != 0));
                        if (exp_q[k].size() != 0) begin
                            check($sformatf("h%0d out_data ch%0d", g, k),
                                  64'(out_data[k*WW +: WW]), 64'(exp_q[k][0]));
                            pop_k[k] = out_ready[k];
                        end
                    end
                    check($sformatf("h%0d sel_err", g), 64'(sel_err), 64'(exp_sel_err));
                end
                @(posedge clk);
                for (int k = 0; k < NN; k++) begin
                    if (pop_k[k] && exp_q[k].size() != 0) void'(exp_q[k].pop_front());
                end
            end
        end

        initial begin : driver
            int oth;
            rst       = 1'b1;
            in_valid  = 1'b0;
            in_sel    = '0;
            in_bcast  = 1'b0;
            in_data   = '0;
            out_ready = '0;
            oth       = (NN > 2) ? NN - 1 : 0;
            #1;
            check($sformatf("h%0d reset out_valid", g), 64'(out_valid), 64'(0));
            check($sformatf("h%0d reset sel_err", g), 64'(sel_err), 64'(0));
            check($sformatf("h%0d reset in_ready", g), 64'(in_ready), 64'(1));
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;

            // unicast streaming to every channel
            for (int k = 0; k < NN; k++) cycle(1'b1, k, 1'b0, WW'(32'hA001 + k), ALL);
            cycle(1'b0, 0, 1'b0, '0, ALL);

            // back-pressure on ch1 must not block another channel
            cycle(1'b1, 1, 1'b0, WW'(32'h1111), ALL & ~NN'(2));
            cycle(1'b1, 1, 1'b0, WW'(32'h2222), ALL & ~NN'(2));
            cycle(1'b1, oth, 1'b0, WW'(32'h3333), ALL & ~NN'(2));
            cycle(1'b1, 1, 1'b0, WW'(32'h2222), ALL);
            cycle(1'b0, 0, 1'b0, '0, ALL);

            // broadcast is all-or-nothing
            cycle(1'b1, 0, 1'b0, WW'(32'h0123), ALL & ~NN'(1));
            cycle(1'b1, 0, 1'b1, WW'(32'hBEEF), ALL & ~NN'(1));
            cycle(1'b1, 0, 1'b1, WW'(32'hBEEF), ALL);
            cycle(1'b0, 0, 1'b0, '0, ALL);

            // highest select code: out of range when NN < 2**SS
            cycle(1'b1, (1 << SS) - 1, 1'b0, WW'(32'hDEAD), ALL);
            cycle(1'b0, 0, 1'b0, '0, ALL);
            cycle(1'b0, 0, 1'b0, '0, ALL);

            // reset while a channel is holding a word
            cycle(1'b1, 2 % NN, 1'b0, WW'(32'h5555), '0);
            do_reset();

            for (int i = 0; i < 400; i++) begin
                cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, (1 << SS) - 1)),
                      $urandom_range(0, 7) == 0, WW'($urandom), NN'($urandom) | NN'($urandom));
            end
            repeat (3) cycle(1'b0, 0, 1'b0, '0, ALL);
            for (int k = 0; k < NN; k++) begin
                check($sformatf("h%0d drained ch%0d", g, k), 64'(exp_q[k].size()), 64'(0));
            end
            done_cnt++;
        end
    end

    initial begin : top_ctl
        for (int t = 0; t < 20000 && done_cnt != 4; t++) @(posedge clk);
        check("all harnesses finished", 64'(done_cnt), 64'(4));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
